// File: rtl/reg_file_if.sv
// Read/write/overflow-status bundle between the register file and its datapath neighbours.
interface reg_file_if #(parameter int DATA_W = 32, parameter int AW = 5);
  logic [AW-1:0]     rd_addr_1;
  logic [AW-1:0]     rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ovf_chk;
  logic              wr_ovf;
  logic              ovf_flag;
  logic [AW-1:0]     ovf_addr;
  logic              ovf_clr;

  modport master (
    output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, wr_ovf_chk, wr_ovf, ovf_clr,
    input  rd_data_1, rd_data_2, ovf_flag, ovf_addr
  );

  modport slave (
    input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, wr_ovf_chk, wr_ovf, ovf_clr,
    output rd_data_1, rd_data_2, ovf_flag, ovf_addr
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write 32x32 MIPS register file with r0 hardwired to zero, write-through
// bypass, and a sticky overflow status that blocks writeback of overflowed results.

module reg_file_rd_lane #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_eff,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    data = stored;
    if (addr == '0)                      data = '0;
    else if (wr_eff && wr_addr == addr)  data = wr_data;
  end
endmodule

module reg_file_2r1w #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_file_if.slave bus
);
  localparam int AW     = $clog2(REG_COUNT);
  localparam int NUM_RD = 2;

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic              wr_blk;
  logic              wr_eff;
  logic              ovf_flag_q;
  logic [AW-1:0]     ovf_addr_q;

  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_stored;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  assign wr_blk = bus.wr_en & bus.wr_ovf_chk & bus.wr_ovf;
  assign wr_eff = bus.wr_en & (bus.wr_addr != '0) & ~(bus.wr_ovf_chk & bus.wr_ovf);

  // Entry 0 is only ever reset, so it stays zero; lanes also force r0 reads to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A clear coinciding with a blocked write re-arms on the new fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag_q <= 1'b0;
      ovf_addr_q <= '0;
    end else if (wr_blk && (!ovf_flag_q || bus.ovf_clr)) begin
      ovf_flag_q <= 1'b1;
      ovf_addr_q <= bus.wr_addr;
    end else if (bus.ovf_clr) begin
      ovf_flag_q <= 1'b0;
      ovf_addr_q <= '0;
    end
  end

  assign rd_addr       = {bus.rd_addr_2, bus.rd_addr_1};
  assign bus.rd_data_1 = rd_data[0];
  assign bus.rd_data_2 = rd_data[1];
  assign bus.ovf_flag  = ovf_flag_q;
  assign bus.ovf_addr  = ovf_addr_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_stored[i] = regs[rd_addr[i]];
    reg_file_rd_lane #(.DATA_W(DATA_W), .AW(AW)) u_lane (
      .addr    (rd_addr[i]),
      .stored  (rd_stored[i]),
      .wr_eff  (wr_eff),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_data[i])
    );
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed vector bench for reg_file_2r1w: table of per-cycle inputs and expected
// combinational/registered outputs, plus hand-written reset sequences.
module tb_reg_file_2r1w;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_if #(.DATA_W(32), .AW(5)) bus ();

  reg_file_2r1w dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ck;
    logic        ov;
    logic        clr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ef;
    logic [4:0]  ea;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ck, input logic ov, input logic clr,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.wr_ovf_chk = ck; bus.wr_ovf = ov; bus.ovf_clr = clr;
    bus.rd_addr_1 = r1; bus.rd_addr_2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, r1, r2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          we   wa     wd            ck   ov   clr  r1     r2     e1            e2            ef   ea
    vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF, 1'b0, 5'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 5'd0};
    vecs[3]  = '{1'b1, 5'd7,  32'h1,        1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 5'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 5'd0};
    vecs[6]  = '{1'b1, 5'd4,  32'h11,       1'b0, 1'b0, 1'b0, 5'd4,  5'd3,  32'h11,       32'hDEADBEEF, 1'b0, 5'd0};
    vecs[7]  = '{1'b1, 5'd4,  32'h80000000, 1'b1, 1'b1, 1'b0, 5'd4,  5'd4,  32'h11,       32'h11,       1'b0, 5'd0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd4,  5'd0,  32'h11,       32'h0,        1'b1, 5'd4};
    vecs[9]  = '{1'b1, 5'd9,  32'h55,       1'b1, 1'b1, 1'b0, 5'd9,  5'd4,  32'h0,        32'h11,       1'b1, 5'd4};
    vecs[10] = '{1'b1, 5'd12, 32'h66,       1'b1, 1'b1, 1'b1, 5'd12, 5'd9,  32'h0,        32'h0,        1'b1, 5'd4};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd9,  5'd12, 32'h0,        32'h0,        1'b1, 5'd12};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0};
    vecs[13] = '{1'b1, 5'd6,  32'h7,        1'b0, 1'b1, 1'b0, 5'd6,  5'd6,  32'h7,        32'h7,        1'b0, 5'd0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd6,  5'd4,  32'h7,        32'h11,       1'b0, 5'd0};
    vecs[15] = '{1'b1, 5'd0,  32'h123,      1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd6,  5'd0,  32'h7,        32'h0,        1'b1, 5'd0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd0,  5'd6,  32'h0,        32'h7,        1'b1, 5'd0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd7,  5'd3,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 5'd0};
    vecs[19] = '{1'b1, 5'd9,  32'h0000CAFE, 1'b1, 1'b0, 1'b0, 5'd9,  5'd9,  32'h0000CAFE, 32'h0000CAFE, 1'b0, 5'd0};
    vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd9,  5'd6,  32'h0000CAFE, 32'h7,        1'b0, 5'd0};
    vecs[21] = '{1'b0, 5'd5,  32'h777,      1'b1, 1'b1, 1'b0, 5'd5,  5'd5,  32'h0,        32'h0,        1'b0, 5'd0};
    vecs[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  5'd12, 32'h0,        32'h0,        1'b0, 5'd0};

    rst_n = 1'b0;
    idle(5'd3, 5'd7);
    #2;
    chk("init_rd1", bus.rd_data_1, 32'h0);
    chk("init_rd2", bus.rd_data_2, 32'h0);
    chk("init_flag", {31'h0, bus.ovf_flag}, 32'h0);
    chk("init_addr", {27'h0, bus.ovf_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Inputs change at negedge, checked 2 units later, latched at the next posedge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ck, vecs[i].ov, vecs[i].clr,
            vecs[i].r1, vecs[i].r2);
      #2;
      chk($sformatf("v%0d_rd1", i), bus.rd_data_1, vecs[i].e1);
      chk($sformatf("v%0d_rd2", i), bus.rd_data_2, vecs[i].e2);
      chk($sformatf("v%0d_flag", i), {31'h0, bus.ovf_flag}, {31'h0, vecs[i].ef});
      chk($sformatf("v%0d_addr", i), {27'h0, bus.ovf_addr}, {27'h0, vecs[i].ea});
    end

    // Leave a fault pending so reset has something to clear.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5);
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5);
    #2;
    chk("r5_stored", bus.rd_data_1, 32'h1234);
    @(negedge clk);
    idle(5'd5, 5'd8);
    #2;
    chk("pre_rst_flag", {31'h0, bus.ovf_flag}, 32'h1);

    // Asynchronous assertion away from any edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rd1_r5", bus.rd_data_1, 32'h0);
    chk("rst_flag", {31'h0, bus.ovf_flag}, 32'h0);
    chk("rst_addr", {27'h0, bus.ovf_addr}, 32'h0);

    // A write held across an edge in reset must not be captured.
    drive(1'b1, 5'd5, 32'h9999, 1'b0, 1'b0, 1'b0, 5'd6, 5'd6);
    @(posedge clk);
    #1;
    idle(5'd5, 5'd5);
    #1;
    chk("rst_no_capture", bus.rd_data_1, 32'h0);

    // Release mid-cycle with a write pending; first rising edge takes it.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h9999, 1'b0, 1'b0, 1'b0, 5'd6, 5'd6);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5'd5, 5'd6);
    #1;
    chk("first_wr_after_rst", bus.rd_data_1, 32'h9999);
    chk("r6_after_rst", bus.rd_data_2, 32'h0);

    for (int r = 1; r < 32; r++) begin
      if (r == 5) continue;
      bus.rd_addr_1 = 5'(r);
      bus.rd_addr_2 = 5'(r);
      #1;
      chk($sformatf("rst_r%0d_p1", r), bus.rd_data_1, 32'h0);
      chk($sformatf("rst_r%0d_p2", r), bus.rd_data_2, 32'h0);
    end
    chk("post_rst_flag", {31'h0, bus.ovf_flag}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
